// File: rtl/uart_pkt_ctrl.sv
// UART packet controller: parses opcode/len headers, echoes (0xEC), sums LE words (0xA0) or drains.
// Optional idle-receive abort compiled in with UART_PKT_TIMEOUT_EN.
module uart_pkt_ctrl #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_tdata_i,
  input  logic       rx_tvalid_i,
  output logic       rx_tready_o,
  output logic [7:0] tx_tdata_o,
  output logic       tx_tvalid_o,
  input  logic       tx_tready_i,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_ECHO, S_ADD_RX, S_DRAIN, S_ADD_TX
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [1:0]  tidx_q, tidx_d;

  logic        rx_fire, tx_fire;
  logic [15:0] len_full, pay_len;

  // ECHO couples the two streams so a stalled transmitter stalls the receiver
  assign rx_tready_o = (state_q == S_ADD_TX) ? 1'b0 :
                       (state_q == S_ECHO)   ? tx_tready_i : 1'b1;
  assign tx_tvalid_o = (state_q == S_ADD_TX) ? 1'b1 :
                       (state_q == S_ECHO)   ? rx_tvalid_i : 1'b0;
  assign tx_tdata_o  = (state_q == S_ADD_TX) ? acc_q[{tidx_q, 3'b000} +: 8] :
                       (state_q == S_ECHO)   ? rx_tdata_i : 8'h00;
  assign busy_o      = (state_q != S_IDLE);
  assign rx_fire     = rx_tvalid_i & rx_tready_o;
  assign tx_fire     = tx_tvalid_o & tx_tready_i;
  assign len_full    = {rx_tdata_i, len_lo_q};
  assign pay_len     = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;

`ifdef UART_PKT_TIMEOUT_EN
  logic [31:0] to_q, to_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    word_d   = word_q;
    bidx_d   = bidx_q;
    tidx_d   = tidx_q;
    err_o    = 1'b0;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        op_d    = rx_tdata_i;
        acc_d   = 32'd0;
        bidx_d  = 2'd0;
        tidx_d  = 2'd0;
        state_d = S_RSV;
      end
      S_RSV: if (rx_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_fire) begin
        len_lo_d = rx_tdata_i;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (rx_fire) begin
        rem_d = pay_len;
        if (op_q == 8'hEC) begin
          state_d = (pay_len == 16'd0) ? S_IDLE : S_ECHO;
        end else if (op_q == 8'hA0) begin
          state_d = (pay_len == 16'd0) ? S_ADD_TX : S_ADD_RX;
        end else begin
          err_o   = 1'b1;
          state_d = (pay_len == 16'd0) ? S_IDLE : S_DRAIN;
        end
      end
      S_ECHO, S_DRAIN: if (rx_fire) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = S_IDLE;
      end
      S_ADD_RX: if (rx_fire) begin
        rem_d  = rem_q - 16'd1;
        bidx_d = bidx_q + 2'd1;
        word_d = {rx_tdata_i, word_q[23:8]};
        // Fourth byte completes the operand; partial trailing groups never reach the adder
        if (bidx_q == 2'd3) acc_d = acc_q + {rx_tdata_i, word_q};
        if (rem_q == 16'd1) state_d = S_ADD_TX;
      end
      S_ADD_TX: if (tx_fire) begin
        tidx_d = tidx_q + 2'd1;
        if (tidx_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_PKT_TIMEOUT_EN
    to_d = 32'd0;
    if (state_q != S_IDLE && state_q != S_ADD_TX && !rx_fire) begin
      if (to_q == TIMEOUT_CYC - 32'd1) begin
        state_d = S_IDLE;
        err_o   = 1'b1;
      end else begin
        to_d = to_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= 8'h00;
      len_lo_q <= 8'h00;
      rem_q    <= 16'd0;
      acc_q    <= 32'd0;
      word_q   <= 24'd0;
      bidx_q   <= 2'd0;
      tidx_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      word_q   <= word_d;
      bidx_q   <= bidx_d;
      tidx_q   <= tidx_d;
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) to_q <= 32'd0;
    else       to_q <= to_d;
  end
`endif

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Randomized and directed bench for uart_pkt_ctrl against a packet-level reference model.
module tb_uart_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] rx_tdata_i;
  logic       rx_tvalid_i;
  logic       rx_tready_o;
  logic [7:0] tx_tdata_o;
  logic       tx_tvalid_o;
  logic       tx_tready_i;
  logic       busy_o;
  logic       err_o;

  always #5 clk = ~clk;

  uart_pkt_ctrl #(.TIMEOUT_CYC(32'd50)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_tdata_i(rx_tdata_i), .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o),
    .tx_tdata_o(tx_tdata_o), .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pk[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] got_tx[$];
  int exp_err = 0, got_err = 0;
  int vld_pct = 100, rdy_pct = 100, stall_left = 0;
  bit rx_acc = 0, prev_stall = 0;
  logic [7:0] prev_dat = 8'h00;
  int cyc = 0, first_fire = -1, last_fire = -1, idle_run = 0, err_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-packet view of what the controller must emit
  task automatic send_pkt();
    int len, p;
    logic [31:0] s;
    len = int'({pk[3], pk[2]});
    p   = (len < 4) ? 0 : len - 4;
    if (pk[0] == 8'hEC) begin
      for (int i = 0; i < p; i++) exp_tx.push_back(pk[4+i]);
    end else if (pk[0] == 8'hA0) begin
      s = 32'd0;
      for (int w = 0; w < p / 4; w++)
        s = s + {pk[4+4*w+3], pk[4+4*w+2], pk[4+4*w+1], pk[4+4*w]};
      for (int k = 0; k < 4; k++) exp_tx.push_back(s[8*k +: 8]);
    end else begin
      exp_err++;
    end
    foreach (pk[i]) rx_q.push_back(pk[i]);
  endtask

  task automatic step();
    @(negedge clk);
    if (rx_acc) begin
      void'(rx_q.pop_front());
      rx_tvalid_i = 1'b0;
      rx_acc = 0;
    end
    if (!rx_tvalid_i && rx_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      rx_tvalid_i = 1'b1;
      rx_tdata_i  = rx_q[0];
    end
    tx_tready_i = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
    #1;
    cyc++;
    if (rx_tvalid_i && rx_tready_o) begin
      rx_acc = 1;
      idle_run = 0;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end else begin
      idle_run++;
    end
    if (tx_tvalid_o && tx_tready_i) got_tx.push_back(tx_tdata_o);
    if (prev_stall) begin
      check("tx_hold_vld", 32'(tx_tvalid_o), 32'd1);
      check("tx_hold_dat", 32'(tx_tdata_o), 32'(prev_dat));
    end
    prev_stall = tx_tvalid_o && !tx_tready_i;
    prev_dat   = tx_tdata_o;
    if (err_o) begin
      got_err++;
      err_gap = idle_run;
    end
    if (stall_left > 0) begin
      check("stall_rx_rdy", 32'(rx_tready_o), 32'd0);
      stall_left--;
    end
  endtask

  task automatic run_done(input string tag, input int bound);
    int n = 0;
    int pending;
    do begin
      step();
      n++;
      pending = rx_q.size() - (rx_acc ? 1 : 0);
    end while ((pending != 0 || busy_o) && n < bound);
    check({tag, "_rx_left"}, 32'(pending), 32'd0);
    check({tag, "_idle"}, 32'(busy_o), 32'd0);
    check({tag, "_ntx"}, 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check({tag, "_txb"}, 32'(got_tx[i]), 32'(exp_tx[i]));
    check({tag, "_nerr"}, 32'(got_err), 32'(exp_err));
    got_tx.delete();
    exp_tx.delete();
    got_err = 0;
    exp_err = 0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    rx_tvalid_i = 1'b0;
    rx_tdata_i = 8'h00;
    tx_tready_i = 1'b0;
    #12;
    check("rst_rx_rdy", 32'(rx_tready_o), 32'd1);
    check("rst_tx_vld", 32'(tx_tvalid_o), 32'd0);
    check("rst_tx_dat", 32'(tx_tdata_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    pk = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    send_pkt();
    run_done("echo3", 200);

    pk = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt();
    run_done("add_wrap", 200);

    pk = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09};
    send_pkt();
    run_done("add_trail", 200);

    first_fire = -1;
    pk = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_pkt();
    pk = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    send_pkt();
    run_done("bad_op", 200);
    check("no_dead_cycle", 32'(last_fire - first_fire + 1), 32'd11);

    // Stall the transmitter mid-echo
    pk = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt();
    n = 0;
    while (got_tx.size() < 1 && n < 100) begin step(); n++; end
    stall_left = 10;
    run_done("echo_stall", 300);

    // Reset during the result phase: the partial result must not resume
    rdy_pct = 0;
    pk = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt();
    n = 0;
    while (!tx_tvalid_o && n < 100) begin step(); n++; end
    check("pre_rst_tx_vld", 32'(tx_tvalid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_tx_vld", 32'(tx_tvalid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    rx_q.delete();
    exp_tx.delete();
    rx_tvalid_i = 1'b0;
    rx_acc = 0;
    prev_stall = 0;
    @(negedge clk);
    rst_i = 1'b0;
    rdy_pct = 100;
    pk = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
    send_pkt();
    run_done("post_rst", 200);

    // Random back-to-back traffic with random handshakes
    vld_pct = 70;
    rdy_pct = 65;
    for (int k = 0; k < 40; k++) begin
      int sel, len;
      sel = int'($urandom_range(3));
      len = int'($urandom_range(24));
      pk.delete();
      case (sel)
        0: pk.push_back(8'hEC);
        1, 2: pk.push_back(8'hA0);
        default: pk.push_back(8'h55 ^ 8'($urandom_range(7) << 1));
      endcase
      pk.push_back(8'($urandom_range(255)));
      pk.push_back(8'(len));
      pk.push_back(8'h00);
      for (int i = 4; i < len; i++) pk.push_back(8'($urandom_range(255)));
      send_pkt();
    end
    run_done("random", 20000);

`ifdef UART_PKT_TIMEOUT_EN
    vld_pct = 100;
    rdy_pct = 100;
    rx_q.push_back(8'hEC);
    rx_q.push_back(8'h00);
    n = 0;
    while (got_err == 0 && n < 300) begin step(); n++; end
    check("tmo_err", 32'(got_err), 32'd1);
    check("tmo_gap", 32'(err_gap), 32'd50);
    step();
    check("tmo_busy", 32'(busy_o), 32'd0);
    got_err = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
